// File: rtl/store_commit_buffer_if.sv
// Commit-stage push port, dcache store request port and load-alias probe of the store commit buffer.
// slave = buffer side, master = environment (commit stage, dcache, load unit).
interface store_commit_buffer_if #(
  parameter int DEPTH = 8,
  parameter int PLEN  = 56,
  parameter int XLEN  = 64
);
  localparam int BEW = XLEN / 8;
  localparam int CW  = $clog2(DEPTH) + 1;

  logic            push_valid_i;
  logic            push_ready_o;
  logic [PLEN-1:0] push_addr_i;
  logic [XLEN-1:0] push_data_i;
  logic [BEW-1:0]  push_be_i;

  logic            req_o;
  logic            gnt_i;
  logic [PLEN-1:0] req_addr_o;
  logic [XLEN-1:0] req_data_o;
  logic [BEW-1:0]  req_be_o;

  logic            empty_o;
  logic [CW-1:0]   count_o;
  logic [11:0]     ld_off_i;
  logic            ld_match_o;

  modport slave (
    input  push_valid_i, push_addr_i, push_data_i, push_be_i, gnt_i, ld_off_i,
    output push_ready_o, req_o, req_addr_o, req_data_o, req_be_o, empty_o, count_o, ld_match_o
  );

  modport master (
    output push_valid_i, push_addr_i, push_data_i, push_be_i, gnt_i, ld_off_i,
    input  push_ready_o, req_o, req_addr_o, req_data_o, req_be_o, empty_o, count_o, ld_match_o
  );
endinterface

// File: rtl/store_commit_buffer.sv
// In-order FIFO of committed stores draining to the dcache via req/gnt, with a load page-offset alias probe.
// Tail-entry store coalescing is compiled in when STORE_BUF_COALESCE_EN is defined.
module store_commit_buffer #(
  parameter int DEPTH = 8,
  parameter int PLEN  = 56,
  parameter int XLEN  = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  store_commit_buffer_if.slave bus
);
  localparam int BEW = XLEN / 8;
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;

  logic [PLEN-1:0] r_addr [DEPTH];
  logic [XLEN-1:0] r_data [DEPTH];
  logic [BEW-1:0]  r_be   [DEPTH];

  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;

  logic [PW-1:0]   w_tail_ptr;
  logic            w_full;
  logic            w_req;
  logic            w_merge_hit;
  logic            w_push_ready;
  logic            w_push_fire;
  logic            w_alloc;
  logic            w_pop;
  logic [DEPTH-1:0] w_valid;
  logic [DEPTH-1:0] w_ld_hit;
  logic [2:0]      w_unused_ld_off;

  assign w_full     = (r_count == CW'(DEPTH));
  assign w_req      = (r_count != '0);
  assign w_tail_ptr = r_wr_ptr - PW'(1);

`ifdef STORE_BUF_COALESCE_EN
  // The presented head must stay stable, so only a tail that is not the head may absorb a push.
  assign w_merge_hit = w_req && (w_tail_ptr != r_rd_ptr) &&
                       (bus.push_addr_i[PLEN-1:3] == r_addr[w_tail_ptr][PLEN-1:3]);
`else
  assign w_merge_hit = 1'b0;
`endif

  assign w_push_ready = !w_full || w_merge_hit;
  assign w_push_fire  = bus.push_valid_i && w_push_ready;
  assign w_alloc      = w_push_fire && !w_merge_hit;
  assign w_pop        = w_req && bus.gnt_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_alloc) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_alloc, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry payload is never reset; validity comes only from the pointers and count.
  always_ff @(posedge clk_i) begin
    if (w_alloc) begin
      r_addr[r_wr_ptr] <= bus.push_addr_i;
      r_data[r_wr_ptr] <= bus.push_data_i;
      r_be[r_wr_ptr]   <= bus.push_be_i;
    end
`ifdef STORE_BUF_COALESCE_EN
    else if (w_push_fire && w_merge_hit) begin
      for (int b = 0; b < BEW; b++) begin
        if (bus.push_be_i[b]) begin
          r_data[w_tail_ptr][8*b +: 8] <= bus.push_data_i[8*b +: 8];
        end
      end
      r_be[w_tail_ptr] <= r_be[w_tail_ptr] | bus.push_be_i;
    end
`endif
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [PW-1:0] w_dist;
      // Distance from the head decides validity, which handles pointer wrap for free.
      assign w_dist        = PW'(gi) - r_rd_ptr;
      assign w_valid[gi]   = ({1'b0, w_dist} < r_count);
      assign w_ld_hit[gi]  = w_valid[gi] && (r_addr[gi][11:3] == bus.ld_off_i[11:3]);
    end
  endgenerate

  assign w_unused_ld_off = bus.ld_off_i[2:0];

  assign bus.push_ready_o = w_push_ready;
  assign bus.req_o        = w_req;
  assign bus.req_addr_o   = r_addr[r_rd_ptr];
  assign bus.req_data_o   = r_data[r_rd_ptr];
  assign bus.req_be_o     = r_be[r_rd_ptr];
  assign bus.empty_o      = !w_req;
  assign bus.count_o      = r_count;
  assign bus.ld_match_o   = |w_ld_hit;
endmodule

// File: doc/store_commit_buffer.md
Name: store_commit_buffer

Overview:
- FIFO of committed stores between the commit stage and the write-back data cache request port.
- Holds up to DEPTH architecturally committed stores and drains them in order through a req/gnt handshake.
- Exposes an empty flag for fences and AMOs.
- Exposes a page-offset match so the load unit can stall loads that may alias a pending store.

Parameters:
- DEPTH, 8, number of store entries; power of two, >= 2.
- PLEN, 56, physical address width.
- XLEN, 64, data width; byte-enable width is XLEN/8.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  asynchronous active-high reset.
- push_valid_i  input  1  commit stage presents a committed store.
- push_ready_o  output  1  buffer can accept a store this cycle.
- push_addr_i  input  PLEN  store physical address, XLEN/8-aligned.
- push_data_i  input  XLEN  store data.
- push_be_i  input  XLEN/8  byte enables.
- req_o  output  1  dcache store request valid.
- gnt_i  input  1  dcache accepts the head entry.
- req_addr_o  output  PLEN  head entry address.
- req_data_o  output  XLEN  head entry data.
- req_be_o  output  XLEN/8  head entry byte enables.
- empty_o  output  1  no pending stores.
- count_o  output  $clog2(DEPTH)+1  number of valid entries.
- ld_off_i  input  12  page offset of a speculative load.
- ld_match_o  output  1  a valid entry matches ld_off_i[11:3].

Behaviour:
- Reset (asynchronous, any cycle, including mid-drain):
  - read/write pointers = 0; count = 0.
  - push_ready_o = 1, req_o = 0, empty_o = 1, count_o = 0, ld_match_o = 0.
  - Entry data/addr/be storage is not reset.
  - Stores pending at reset are discarded; the dcache may still complete a previously granted request.
- Push:
  - Accepted when push_valid_i && push_ready_o.
  - Entry written at the write pointer on that clock edge; write pointer and count increment.
  - push_ready_o = (count < DEPTH), registered-state based only; no same-cycle pop bypass.
  - Full buffer with gnt_i high: push still refused that cycle.
- Drain:
  - req_o = (count != 0).
  - req_addr_o/req_data_o/req_be_o driven from the head entry.
  - All four request outputs stay stable while req_o && !gnt_i.
  - gnt_i while req_o = 1: head popped at the edge; read pointer increments; next entry presented the following cycle.
  - gnt_i with req_o = 0 is ignored.
- Latency:
  - Store pushed into an empty buffer appears on req_o one cycle after the push edge.
  - Back-to-back grants sustain one store per cycle.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Pointers: log2(DEPTH) bits, wrap naturally; full and empty are decided by count, not pointer compare.
- empty_o = (count == 0); count_o = count register.
- ld_match_o: combinational OR over valid entries of (entry.addr[11:3] == ld_off_i[11:3]). Byte enables are ignored; this is conservative.
- In-order drain; stores are never reordered or dropped.

Optional Feature:
- Macro: STORE_BUF_COALESCE_EN.
- Defined:
  - A push merges into the tail entry when all of the following hold:
    - push_addr_i[PLEN-1:3] equals the tail entry address;
    - count >= 1;
    - the tail is not the head currently presented with req_o.
  - Merge action: bytes where push_be_i = 1 overwrite tail data; tail be |= push_be_i.
  - Count and pointers are unchanged by a merge.
  - A merging push is accepted even when full, so push_ready_o = (count < DEPTH) || merge_hit.
- Undefined: every push allocates a new entry; no merge logic is present.

Test Plan:
- Reset mid-operation: push 3 stores, assert rst_i for 1 cycle -> empty_o = 1, req_o = 0, count_o = 0 immediately; next push appears at req_o one cycle later.
- Single store: push addr 0x8000_0010, data 0x1122334455667788, be 0xFF into empty buffer -> req_o = 1 next cycle with identical addr/data/be; gnt_i one cycle later -> empty_o = 1 the cycle after.
- Backpressure: gnt_i held 0; push 8 stores -> push_ready_o = 0 and count_o = 8; req outputs stable for 20 cycles; gnt_i = 1 for 8 cycles -> stores emitted in push order.
- Full + simultaneous: full buffer, push_valid_i = 1 with gnt_i = 1 -> push refused, count_o = 7; next cycle push accepted with gnt_i = 1 -> count_o stays 7.
- Load alias: pending store at 0x8000_1238; ld_off_i = 0x23C -> ld_match_o = 1; ld_off_i = 0x240 -> ld_match_o = 0.
- Coalesce (STORE_BUF_COALESCE_EN): gnt_i = 0, head at 0x100; push 0x200 be 0x0F, then 0x200 be 0xF0 -> count_o = 2, second entry be = 0xFF with merged data; with macro undefined -> count_o = 3.
